// File: rtl/capture_sequencer.sv
// capture_sequencer: sample-tick generator, channel enable driver and
// lowest-channel-first word serialiser for a bank of 16-bit deserializers.
// Optional macro CAPTURE_SEQ_CHTAG_EN adds fifo_chan (channel index of fifo_data).
module capture_sequencer #(
    parameter int NUM_CH = 16,
    parameter int DIV_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic [DIV_W-1:0]     divisor,
    input  logic [NUM_CH-1:0]    ch_mask,
    output logic                 s2p_tick,
    output logic [NUM_CH-1:0]    s2p_enable,
    input  logic [NUM_CH-1:0]    s2p_ready,
    input  logic [NUM_CH*16-1:0] s2p_data,
    output logic [15:0]          fifo_data,
    output logic                 fifo_valid,
    input  logic                 fifo_ready,
    output logic                 running,
`ifdef CAPTURE_SEQ_CHTAG_EN
    output logic [3:0]           fifo_chan,
`endif
    output logic                 overflow
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HALT} state_t;

    state_t              r_state, w_state_nxt;
    logic [NUM_CH-1:0]   r_mask;
    logic [DIV_W-1:0]    r_div;
    logic [DIV_W-1:0]    r_presc;
    logic [NUM_CH-1:0]   r_pending, w_pend_nxt;
    logic                r_overflow;
    logic [15:0]         r_buf [NUM_CH];

    logic [NUM_CH-1:0]   w_rdy;
    logic                w_run, w_cap, w_ovr, w_acc, w_start_ok, w_tick;
    logic [3:0]          w_sel;

    assign w_run      = (r_state == S_RUN);
    assign w_rdy      = s2p_ready & r_mask;
    assign w_cap      = w_run && (w_rdy != '0) && (r_pending == '0);
    // a new word set arriving while the previous one is still draining is lost
    assign w_ovr      = w_run && (w_rdy != '0) && (r_pending != '0);
    assign w_acc      = fifo_valid && fifo_ready;
    assign w_start_ok = start && !stop && (ch_mask != '0);
    assign w_tick     = w_run && (r_presc == r_div);

    // lowest-index pending channel owns the output
    always_comb begin
        w_sel = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (r_pending[i]) w_sel = i[3:0];
    end

    // pending bitmap: load a full set on capture, drop the lowest bit on accept
    always_comb begin
        w_pend_nxt = r_pending;
        if (w_cap)
            w_pend_nxt = w_rdy;
        else if (w_acc)
            w_pend_nxt = r_pending & (r_pending - 1'b1);
    end

    // next state: leave DRAIN (or RUN on stop/overrun) as soon as nothing remains pending
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_HALT: if (w_start_ok) w_state_nxt = S_RUN;
            S_RUN: begin
                if (w_ovr || stop) begin
                    if (w_pend_nxt != '0)
                        w_state_nxt = S_DRAIN;
                    else
                        w_state_nxt = w_ovr ? S_HALT : S_IDLE;
                end
            end
            S_DRAIN: if (w_pend_nxt == '0) w_state_nxt = r_overflow ? S_HALT : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // control state, configuration latches, prescaler and overrun flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_mask     <= '0;
            r_div      <= '0;
            r_presc    <= '0;
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pend_nxt;
            if ((r_state == S_IDLE || r_state == S_HALT) && w_start_ok) begin
                r_mask     <= ch_mask;
                r_div      <= divisor;
                r_overflow <= 1'b0;
            end
            if (w_ovr) r_overflow <= 1'b1;
            r_presc <= (w_run && !w_tick) ? r_presc + 1'b1 : '0;
        end
    end

    // holding buffer: words are only written when the pending set is empty
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++)
            if (w_cap && w_rdy[i]) r_buf[i] <= s2p_data[16*i +: 16];
    end

    // output drive
    always_comb begin
        s2p_tick   = w_tick;
        s2p_enable = (r_state == S_RUN || r_state == S_DRAIN) ? r_mask : '0;
        running    = (r_state == S_RUN || r_state == S_DRAIN);
        overflow   = r_overflow;
        fifo_valid = (r_pending != '0);
        fifo_data  = fifo_valid ? r_buf[w_sel] : 16'h0;
`ifdef CAPTURE_SEQ_CHTAG_EN
        fifo_chan  = fifo_valid ? w_sel : 4'h0;
`endif
    end

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer; the bench drives the deserializer
// ready/data lines directly. Build with CAPTURE_SEQ_CHTAG_EN to cover fifo_chan.
module tb_capture_sequencer;

    localparam int NUM_CH = 16;
    localparam int DIV_W  = 16;

    logic                 clk = 1'b0;
    logic                 rst, start, stop, fifo_ready;
    logic [DIV_W-1:0]     divisor;
    logic [NUM_CH-1:0]    ch_mask, s2p_ready, s2p_enable;
    logic [NUM_CH*16-1:0] s2p_data;
    logic                 s2p_tick, fifo_valid, running, overflow;
    logic [15:0]          fifo_data;
`ifdef CAPTURE_SEQ_CHTAG_EN
    logic [3:0]           fifo_chan;
`endif

    int n_tot = 0;
    int n_bad = 0;

    capture_sequencer #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .divisor(divisor), .ch_mask(ch_mask),
        .s2p_tick(s2p_tick), .s2p_enable(s2p_enable),
        .s2p_ready(s2p_ready), .s2p_data(s2p_data),
        .fifo_data(fifo_data), .fifo_valid(fifo_valid), .fifo_ready(fifo_ready),
        .running(running),
`ifdef CAPTURE_SEQ_CHTAG_EN
        .fifo_chan(fifo_chan),
`endif
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [NUM_CH-1:0] m, input logic [DIV_W-1:0] d);
        ch_mask = m; divisor = d; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; fifo_ready = 1'b1;
        divisor = '0; ch_mask = '0; s2p_ready = '0; s2p_data = '0;
        step(); step();
        rst = 1'b0;
        chk("rst_valid", fifo_valid, 0);
        chk("rst_data", fifo_data, 0);
        chk("rst_tick", s2p_tick, 0);
        chk("rst_en", s2p_enable, 0);
        chk("rst_run", running, 0);
        chk("rst_ovf", overflow, 0);

        // two-channel capture, divisor 0
        do_start(16'h0003, 0);
        chk("a_run", running, 1);
        chk("a_en", s2p_enable, 16'h0003);
        chk("a_tick", s2p_tick, 1);
        s2p_ready = 16'h0003;
        s2p_data[15:0] = 16'hA5A5; s2p_data[31:16] = 16'h3C3C;
        step();
        s2p_ready = '0;
        chk("a_v1", fifo_valid, 1);
        chk("a_d1", fifo_data, 16'hA5A5);
        step();
        chk("a_v2", fifo_valid, 1);
        chk("a_d2", fifo_data, 16'h3C3C);
        step();
        chk("a_v3", fifo_valid, 0);
        chk("a_ovf", overflow, 0);
        stop = 1'b1; step(); stop = 1'b0;
        chk("a_stop_run", running, 0);
        chk("a_stop_en", s2p_enable, 0);

        // divisor 3: ticks every 4th cycle, word after 16 ticks, then stop after 5 more
        do_start(16'h0001, 3);
        for (int c = 1; c <= 64; c++) begin
            chk("b_tick", s2p_tick, (c % 4 == 0) ? 1 : 0);
            if (c < 64) step();
        end
        step();                      // cycle 65: deserializer reports word
        s2p_ready = 16'h0001; s2p_data[15:0] = 16'h1234;
        step();                      // cycle 66
        s2p_ready = '0;
        chk("b_v", fifo_valid, 1);
        chk("b_d", fifo_data, 16'h1234);
        for (int c = 67; c <= 84; c++) begin
            step();
            chk("b_tick2", s2p_tick, (c % 4 == 0) ? 1 : 0);
            chk("b_v2", fifo_valid, 0);
        end
        stop = 1'b1; step(); stop = 1'b0;
        chk("b_stop_run", running, 0);
        chk("b_stop_en", s2p_enable, 0);
        chk("b_stop_tick", s2p_tick, 0);
        chk("b_stop_v", fifo_valid, 0);
        for (int c = 0; c < 4; c++) begin
            step();
            chk("b_post_tick", s2p_tick, 0);
        end

        // overrun with back-pressure
        fifo_ready = 1'b0;
        do_start(16'h0007, 0);
        s2p_ready = 16'h0007;
        s2p_data[15:0] = 16'h1111; s2p_data[31:16] = 16'h2222; s2p_data[47:32] = 16'h3333;
        step();
        s2p_ready = '0;
        chk("c_v", fifo_valid, 1);
        chk("c_d", fifo_data, 16'h1111);
        for (int c = 0; c < 15; c++) begin
            step();
            chk("c_hold", fifo_data, 16'h1111);
        end
        chk("c_ovf0", overflow, 0);
        s2p_ready = 16'h0007;
        s2p_data[15:0] = 16'hAAAA; s2p_data[31:16] = 16'hBBBB; s2p_data[47:32] = 16'hCCCC;
        step();
        s2p_ready = '0;
        chk("c_ovf1", overflow, 1);
        chk("c_tick", s2p_tick, 0);
        chk("c_run", running, 1);
        chk("c_d_kept", fifo_data, 16'h1111);
        fifo_ready = 1'b1;
        step();
        chk("c_d2", fifo_data, 16'h2222);
        step();
        chk("c_d3", fifo_data, 16'h3333);
        step();
        chk("c_v_end", fifo_valid, 0);
        chk("c_halt_run", running, 0);
        chk("c_halt_en", s2p_enable, 0);
        step();
        chk("c_halt_ovf", overflow, 1);
        stop = 1'b1; step(); stop = 1'b0;
        chk("c_halt_stop", overflow, 1);
        do_start(16'h0001, 0);
        chk("c_restart_run", running, 1);
        chk("c_restart_ovf", overflow, 0);
        stop = 1'b1; step(); stop = 1'b0;
        chk("c_idle", running, 0);

        // ignored starts
        do_start(16'h0000, 0);
        chk("d_mask0", running, 0);
        stop = 1'b1;
        do_start(16'h0001, 0);
        stop = 1'b0;
        chk("d_startstop", running, 0);

        // reset with two words pending
        fifo_ready = 1'b0;
        do_start(16'h0003, 0);
        s2p_ready = 16'h0003;
        s2p_data[15:0] = 16'h5555; s2p_data[31:16] = 16'h6666;
        step();
        s2p_ready = '0;
        chk("e_v", fifo_valid, 1);
        rst = 1'b1; step();
        chk("e_valid", fifo_valid, 0);
        chk("e_data", fifo_data, 0);
        chk("e_run", running, 0);
        chk("e_en", s2p_enable, 0);
        chk("e_tick", s2p_tick, 0);
        chk("e_ovf", overflow, 0);
        rst = 1'b0; fifo_ready = 1'b1;
        step();
        chk("e_valid2", fifo_valid, 0);

        // channels 0 and 15
        do_start(16'h8001, 0);
        s2p_ready = 16'h8001;
        s2p_data = '0;
        s2p_data[15:0] = 16'hBEEF; s2p_data[255:240] = 16'hCAFE;
        step();
        s2p_ready = '0;
        chk("f_d0", fifo_data, 16'hBEEF);
`ifdef CAPTURE_SEQ_CHTAG_EN
        chk("f_chan0", fifo_chan, 0);
`endif
        step();
        chk("f_d15", fifo_data, 16'hCAFE);
`ifdef CAPTURE_SEQ_CHTAG_EN
        chk("f_chan15", fifo_chan, 15);
`endif
        step();
        chk("f_v_end", fifo_valid, 0);
`ifdef CAPTURE_SEQ_CHTAG_EN
        chk("f_chan_idle", fifo_chan, 0);
`endif
        stop = 1'b1; step(); stop = 1'b0;
        chk("f_idle", running, 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/capture_sequencer.md
Name: capture_sequencer

Overview:
Sequencer and arbiter for a bank of NUM_CH 16-bit serial-to-parallel deserializers, one per logic-analyser probe channel. It generates the shared sample tick from a programmable divisor and drives the per-channel enables. It captures completed 16-bit words from all ready channels and serialises them, lowest channel first, onto a single valid/ready stream toward the capture FIFO. It detects and flags overruns.

Parameters:
NUM_CH, 16, number of deserializer channels (1..16)
DIV_W, 16, width of sample-rate divisor

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  one-cycle pulse: begin capture
stop  in  1  one-cycle pulse: end capture
divisor  in  DIV_W  tick period minus one; sampled on accepted start
ch_mask  in  NUM_CH  enabled channels; sampled on accepted start
s2p_tick  out  1  shared sample tick to all deserializers
s2p_enable  out  NUM_CH  per-channel deserializer enable
s2p_ready  in  NUM_CH  per-channel word-complete flag; high one cycle
s2p_data  in  NUM_CH*16  concatenated words; channel i at [16i+15:16i]
fifo_data  out  16  output word
fifo_valid  out  1  output word valid
fifo_ready  in  1  downstream accept
running  out  1  high in RUN or DRAIN
overflow  out  1  sticky overrun flag

Behaviour:
- Reset: synchronous, active-high on rst; clock clk. All outputs 0. State IDLE. Prescaler 0. Pending bitmap 0.
- States: IDLE, RUN, DRAIN, HALT.
- IDLE:
  - s2p_enable = 0.
  - start with ch_mask != 0 and stop = 0 -> RUN. Latch mask, latch divisor, clear overflow, clear prescaler.
  - start with ch_mask == 0 is ignored.
  - start and stop in the same cycle: stop wins, start ignored.
- RUN:
  - s2p_enable = latched mask.
  - Prescaler counts 0..divisor. s2p_tick is 1 for the cycle when prescaler == divisor, then the prescaler returns to 0.
  - divisor = 0 gives a tick every cycle. The first tick occurs divisor+1 cycles after entering RUN.
- Capture:
  - In any cycle where (s2p_ready & mask) != 0 and pending == 0: copy those channels' words into a holding buffer and set the matching pending bits.
- Output arbiter:
  - While pending != 0: fifo_valid = 1; fifo_data = word of lowest-index pending channel.
  - On fifo_valid && fifo_ready, clear that pending bit. The next word is presented the following cycle.
  - fifo_data is stable while fifo_valid && !fifo_ready.
  - Latency: ready set observed in cycle T gives first fifo_valid in T+1. With fifo_ready held high, one word is delivered per cycle.
- Overrun:
  - Condition: (s2p_ready & mask) != 0 while pending != 0.
  - Response: the new ready set is discarded and overflow := 1.
  - State -> DRAIN: ticks stop, already-pending words are still delivered, then -> HALT.
  - HALT: s2p_enable = 0, running = 0, overflow held. Leave HALT only via start (-> RUN, clears overflow) or rst.
- Stop:
  - stop in RUN -> DRAIN. s2p_tick stops immediately and s2p_enable is held.
  - When pending == 0 -> IDLE and s2p_enable drops. Partial words in the deserializers are discarded.
  - stop in DRAIN or HALT is ignored.
- running = 1 exactly in RUN and DRAIN. start while running is ignored.
- Sustainable throughput: popcount(mask) <= 16*(divisor+1) cycles per word set, with fifo_ready constantly high.
- rst mid-operation: immediate return to reset state. Pending words are lost and no fifo_valid is asserted after rst.

Optional Feature:
Macro CAPTURE_SEQ_CHTAG_EN.
- Defined: adds output port fifo_chan, 4 bits. It carries the channel index of the word on fifo_data and is valid and stable under the same rules as fifo_data; reset 0.
- Undefined: port absent; untagged words in ascending channel order per set is the only ordering guarantee.

Test Plan:
- mask=0x0003, divisor=0, fifo_ready=1, deserializers fed ch0=0xA5A5 and ch1=0x3C3C -> ready at cycle T; fifo_data 0xA5A5 at T+1 and 0x3C3C at T+2; fifo_valid low at T+3; overflow=0.
- divisor=3, mask=0x0001 -> s2p_tick pulses on cycles 4, 8, 12... after start; first word after 16 ticks (cycle 64 plus deserializer latency).
- fifo_ready=0, mask=0x0007, divisor=0 -> first set held with stable fifo_data; second ready set after 16 cycles sets overflow=1 and ticks stop. Releasing fifo_ready delivers exactly the first 3 words; then HALT, running=0.
- stop after 5 ticks of a word -> no ticks after stop, no fifo_valid; running drops next cycle; s2p_enable=0.
- start with ch_mask=0 -> stays IDLE. start and stop in the same cycle -> stays IDLE. rst asserted while 2 words pending -> all outputs 0 next cycle.
- CAPTURE_SEQ_CHTAG_EN defined, mask=0x8001 -> fifo_chan = 0 then 15, aligned with the respective words.
